// File: rtl/array_frame_pkg.sv
// Shared definitions for the frame accumulator.
//   state_t : LOAD / SUM / OUT controller states
//   D*_DEF, N : default frame geometry and element count
//   idx_w() : index width for a dimension (never below 1 bit)
//   sext()  : sign-extends the low iw bits of x to 64 bits
package array_frame_pkg;

   typedef enum logic [1:0] {LOAD, SUM, OUT} state_t;

   localparam int D0_DEF = 2;
   localparam int D1_DEF = 3;
   localparam int D2_DEF = 4;
   localparam int N      = D0_DEF * D1_DEF * D2_DEF;

   function automatic int idx_w(input int d);
      return (d <= 1) ? 1 : $clog2(d);
   endfunction

   // Move the sign bit to bit 63, then arithmetic-shift back down.
   function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned iw);
      logic signed [63:0] t;
      t = $signed(x << (64 - iw));
      return 64'(t >>> (64 - iw));
   endfunction

endpackage

// File: rtl/array_frame_idx_ctr.sv
// Three-level wrapping index counter (i outer, j middle, k fastest).
//   clk, rst : clock, async active-high reset (indices to 0)
//   en       : advance one element
//   clr      : synchronous return to (0,0,0), wins over en
//   i, j, k  : current indices
//   last     : indices point at (D0-1, D1-1, D2-1)
module array_frame_idx_ctr
   import array_frame_pkg::*;
#(
   parameter int D0 = D0_DEF,
   parameter int D1 = D1_DEF,
   parameter int D2 = D2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   output logic [idx_w(D0)-1:0]  i,
   output logic [idx_w(D1)-1:0]  j,
   output logic [idx_w(D2)-1:0]  k,
   output logic                  last
);

   localparam int IW0 = idx_w(D0);
   localparam int IW1 = idx_w(D1);
   localparam int IW2 = idx_w(D2);
   localparam logic [IW0-1:0] I_MAX = IW0'(D0 - 1);
   localparam logic [IW1-1:0] J_MAX = IW1'(D1 - 1);
   localparam logic [IW2-1:0] K_MAX = IW2'(D2 - 1);

   logic [IW0-1:0] i_q, i_d;
   logic [IW1-1:0] j_q, j_d;
   logic [IW2-1:0] k_q, k_d;

   always_comb begin
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      if (clr) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end else if (en) begin
         if (k_q == K_MAX) begin
            k_d = '0;
            if (j_q == J_MAX) begin
               j_d = '0;
               i_d = (i_q == I_MAX) ? '0 : i_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
         end else begin
            k_d = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
      end
   end

   assign i    = i_q;
   assign j    = j_q;
   assign k    = k_q;
   assign last = (i_q == I_MAX) && (j_q == J_MAX) && (k_q == K_MAX);

endmodule

// File: rtl/array_frame_accum.sv
// Loads a D0 x D1 x D2 frame of signed IW-bit elements (k fastest), then sums
// it one element per cycle into an OW-bit accumulator and offers the sum on a
// valid/ready port.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : element stream handshake, in_data is the element
//   out_valid/out_ready : frame sum handshake, out_sum is the signed sum
//   busy                : summing or holding a result
//
//   state | meaning
//   LOAD  | accepting elements into the buffer
//   SUM   | adding one buffered element per cycle
//   OUT   | sum presented, waiting for out_ready
module array_frame_accum
   import array_frame_pkg::*;
#(
   parameter int D0 = D0_DEF,
   parameter int D1 = D1_DEF,
   parameter int D2 = D2_DEF,
   parameter int IW = 16,
   parameter int OW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_sum,
   output logic          busy
);

   if (OW < IW) begin : g_ow_lt_iw
      $error("array_frame_accum: OW must be >= IW");
   end
   if (OW > 64) begin : g_ow_gt_64
      $error("array_frame_accum: OW must be <= 64");
   end

   state_t         state_q, state_d;
   logic [OW-1:0]  acc_q, acc_d;
   logic [OW-1:0]  out_sum_q, out_sum_d;
   logic           out_valid_q, out_valid_d;
   logic           in_ready_q, in_ready_d;

   logic                 ctr_en, ctr_clr, ctr_last;
   logic [idx_w(D0)-1:0] ctr_i;
   logic [idx_w(D1)-1:0] ctr_j;
   logic [idx_w(D2)-1:0] ctr_k;
   logic                 buf_we;
   logic [OW-1:0]        elem_ext;

   // No reset: every location is written during LOAD before SUM reads it.
   logic [IW-1:0] buf_q [D0][D1][D2];

   array_frame_idx_ctr #(.D0(D0), .D1(D1), .D2(D2)) u_idx (
      .clk  (clk),
      .rst  (rst),
      .en   (ctr_en),
      .clr  (ctr_clr),
      .i    (ctr_i),
      .j    (ctr_j),
      .k    (ctr_k),
      .last (ctr_last)
   );

   assign elem_ext = OW'(sext(64'(buf_q[ctr_i][ctr_j][ctr_k]), IW));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;
      ctr_en      = 1'b0;
      ctr_clr     = 1'b0;
      buf_we      = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_valid && in_ready_q) begin
               buf_we = 1'b1;
               ctr_en = 1'b1;
               if (ctr_last) state_d = SUM;
            end
         end
         SUM: begin
            // The counter wraps to (0,0,0) on the last element, ready for the next LOAD.
            acc_d  = acc_q + elem_ext;
            ctr_en = 1'b1;
            if (ctr_last) begin
               out_sum_d   = acc_d;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               ctr_clr     = 1'b1;
               state_d     = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
      // Registered so it stays low for the first cycle after reset release.
      in_ready_d = (state_d == LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         acc_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) buf_q[ctr_i][ctr_j][ctr_k] <= in_data;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign busy      = (state_q == SUM) || (state_q == OUT);

endmodule
